cache_refill: RTL and testbench
===============================

# cache_refill

Miss-side refill engine for the direct-mapped instruction cache: 8 lines, each holding four 16-bit words.
- On a miss it fetches the four 16-bit words of the missing line from instruction memory using a req/ack handshake.
- It packs them into a 64-bit line and presents that line, with its base address, to the cache fill port for one cycle.
- It sits between the cache (miss/address in, line out) and the memory port, and is the writer for the cache's line-data input.

## Interface
Parameters:
- ADDR_W, 16, byte address width
- WORD_W, 16, instruction/memory word width
- LINE_WORDS, 4, words per cache line (fixed; line = 64 bits)

Ports:
- inp_clk  in  1  clock, all state updates on rising edge
- inp_rst_n  in  1  reset, asynchronous assert, active-low
- inp_miss  in  1  cache lookup missed this cycle
- inp_address  in  16  byte address of the missing fetch
- out_busy  out  1  refill in progress (any state other than IDLE)
- out_mem_req  out  1  memory read request
- out_mem_addr  out  16  byte address of the word being requested
- inp_mem_ack  in  1  memory has valid data on inp_mem_data this cycle
- inp_mem_data  in  16  memory read data
- out_lineData  out  64  assembled line; word k is in bits [16k+15:16k]
- out_line_addr  out  16  line base address {inp_address[15:3], 3'b000}
- out_line_valid  out  1  one-cycle pulse: out_lineData and out_line_addr are a new line

## Operation
States: IDLE, FETCH, FILL.

IDLE:
- out_busy=0, out_mem_req=0.
- If inp_miss=1 at a rising edge:
  - latch base = {inp_address[15:3],3'b000};
  - set word index idx=0;
  - go to FETCH.

FETCH:
- out_mem_req=1, out_mem_addr = base + 2·idx.
- At a rising edge with inp_mem_ack=1:
  - write inp_mem_data into buffer word idx;
  - if idx==3, go to FILL; otherwise idx+1 and stay in FETCH.
- With inp_mem_ack=0: hold; req and address stay stable.

FILL:
- out_line_valid=1 for exactly this cycle.
- out_lineData and out_line_addr are loaded from the buffer/base on the edge entering FILL.
- Next edge always returns to IDLE.

Rules and boundary conditions:
- inp_miss is ignored while out_busy=1; it is also ignored in FILL. Misses are not queued.
- inp_mem_ack is ignored in IDLE and FILL.
- out_lineData and out_line_addr change only on the edge entering FILL. Between fills they hold the last line, so the cache's data-change-sensitive fill input sees exactly one update per refill.
- Address arithmetic is 16-bit. The highest base is 0xFFF8 and its last word is 0xFFFE, so there is never a carry out of bits [2:0].
- Word order matches the cache's selection by inp_address[2:1]: word at base+0 goes to bits [15:0], word at base+6 to bits [63:48].
- Reset mid-refill: the partial line is discarded, no out_line_valid pulse is produced, and the block returns to IDLE.
- Reset values: state IDLE, idx 0, out_busy 0, out_mem_req 0, out_mem_addr 0x0000, out_lineData 0, out_line_addr 0x0000, out_line_valid 0.

## Timing
- Miss sampled at edge E0 → out_mem_req=1 with addr=base from after E0.
- Word k is captured at the first edge where req=1 and ack=1 for that word.
- Minimum refill (ack high every cycle): words captured at E1..E4, out_line_valid high between E4 and E5, IDLE after E5. The earliest next miss is accepted at E6.
- Memory wait states extend FETCH one cycle per low-ack cycle. There is no timeout.
- out_mem_addr advances on the same edge that captures the acked word.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package cache_pkg:
  - CACHE_LINES=8, LINE_WORDS=4, WORD_W=16, LINE_W=64;
  - TAG bit range [15:6], INDEX range [5:3], OFFSET range [2:1];
  - refill state encoding (IDLE=2'd0, FETCH=2'd1, FILL=2'd2).
- The package is shared with the cache.
- Single module. No sub-module; the line buffer is four WORD_W registers indexed by idx.

## Test plan
- Reset, then miss at 0x1234 with ack tied high:
  - mem addrs 0x1230, 0x1232, 0x1234, 0x1236 on consecutive cycles;
  - data 0xAAAA, 0xBBBB, 0xCCCC, 0xDDDD → out_lineData=0xDDDD_CCCC_BBBB_AAAA, out_line_addr=0x1230, one-cycle valid pulse at E4–E5.
- Same miss with 2 wait cycles before each ack → req/addr held stable during waits; valid pulse 8 cycles later than the no-wait case.
- Second miss (0x4000) asserted during a refill → ignored, only one fill pulse; a miss at 0x4000 after return to IDLE starts a new refill at base 0x4000.
- Miss at 0xFFFE → addrs 0xFFF8..0xFFFE, out_line_addr=0xFFF8, no wrap.
- inp_rst_n pulled low after 2 of 4 words acked → all outputs 0 immediately, no valid pulse, IDLE. A later miss refills cleanly.
- Spurious inp_mem_ack in IDLE with data 0x5555 → out_lineData unchanged, no valid pulse.

Source files
------------

// File: rtl/cache_pkg.sv
// Shared instruction-cache definitions: geometry, address field ranges and
// the refill engine state encoding, used by both the cache and its refill engine.
package cache_pkg;

  localparam int CACHE_LINES = 8;
  localparam int LINE_WORDS  = 4;
  localparam int WORD_W      = 16;
  localparam int LINE_W      = 64;
  localparam int ADDR_W      = 16;

  localparam int TAG_HI    = 15;
  localparam int TAG_LO    = 6;
  localparam int INDEX_HI  = 5;
  localparam int INDEX_LO  = 3;
  localparam int OFFSET_HI = 2;
  localparam int OFFSET_LO = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_FILL  = 2'd2
  } refill_state_e;

  function automatic logic [ADDR_W-1:0] line_base(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:INDEX_LO], 3'b000};
  endfunction

endpackage

// File: rtl/cache_refill_if.sv
// Bundle of the refill engine's cache-side and memory-side signals.
// The master modport is the refill engine; slave is the cache/memory side.
interface cache_refill_if #(
  parameter int ADDR_W     = 16,
  parameter int WORD_W     = 16,
  parameter int LINE_WORDS = 4
);

  logic                         inp_miss;
  logic [ADDR_W-1:0]            inp_address;
  logic                         out_busy;
  logic                         out_mem_req;
  logic [ADDR_W-1:0]            out_mem_addr;
  logic                         inp_mem_ack;
  logic [WORD_W-1:0]            inp_mem_data;
  logic [WORD_W*LINE_WORDS-1:0] out_lineData;
  logic [ADDR_W-1:0]            out_line_addr;
  logic                         out_line_valid;

  modport master (
    input  inp_miss, inp_address, inp_mem_ack, inp_mem_data,
    output out_busy, out_mem_req, out_mem_addr,
    output out_lineData, out_line_addr, out_line_valid
  );

  modport slave (
    output inp_miss, inp_address, inp_mem_ack, inp_mem_data,
    input  out_busy, out_mem_req, out_mem_addr,
    input  out_lineData, out_line_addr, out_line_valid
  );

endinterface

// File: rtl/cache_refill.sv
// Miss-side refill engine: fetches the four words of a missing line over a
// req/ack memory port and presents the packed line to the cache for one cycle.
module cache_refill
  import cache_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int WORD_W     = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic           inp_clk,
  input  logic           inp_rst_n,
  cache_refill_if.master bus
);

  localparam int IDX_W   = $clog2(LINE_WORDS);
  localparam int LINE_WL = WORD_W * LINE_WORDS;

  refill_state_e        state_q, state_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [IDX_W-1:0]     idx_inc_s;
  logic [ADDR_W-1:0]    base_q, base_d;
  logic [WORD_W-1:0]    wbuf_q [LINE_WORDS];
  logic [WORD_W-1:0]    wbuf_d [LINE_WORDS];
  logic                 busy_q, busy_d;
  logic                 mem_req_q, mem_req_d;
  logic [ADDR_W-1:0]    mem_addr_q, mem_addr_d;
  logic [LINE_WL-1:0]   line_data_q, line_data_d;
  logic [ADDR_W-1:0]    line_addr_q, line_addr_d;
  logic                 line_valid_q, line_valid_d;

  assign idx_inc_s = idx_q + IDX_W'(1);

  // Next-state, word capture and output register values
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    base_d       = base_q;
    wbuf_d       = wbuf_q;
    busy_d       = busy_q;
    mem_req_d    = mem_req_q;
    mem_addr_d   = mem_addr_q;
    line_data_d  = line_data_q;
    line_addr_d  = line_addr_q;
    line_valid_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.inp_miss) begin
          state_d    = ST_FETCH;
          base_d     = {bus.inp_address[ADDR_W-1:3], 3'b000};
          idx_d      = {IDX_W{1'b0}};
          busy_d     = 1'b1;
          mem_req_d  = 1'b1;
          mem_addr_d = {bus.inp_address[ADDR_W-1:3], 3'b000};
        end else begin
          busy_d    = 1'b0;
          mem_req_d = 1'b0;
        end
      end

      ST_FETCH: begin
        if (bus.inp_mem_ack) begin
          wbuf_d[idx_q] = bus.inp_mem_data;
          if (idx_q == IDX_W'(LINE_WORDS - 1)) begin
            // Line is complete: publish it on the edge that enters FILL
            state_d      = ST_FILL;
            mem_req_d    = 1'b0;
            line_addr_d  = base_q;
            line_valid_d = 1'b1;
            for (int k = 0; k < LINE_WORDS; k++) begin
              line_data_d[k*WORD_W +: WORD_W] = wbuf_d[k];
            end
          end else begin
            idx_d      = idx_inc_s;
            mem_addr_d = base_q + {{(ADDR_W-IDX_W-1){1'b0}}, idx_inc_s, 1'b0};
          end
        end else begin
          state_d = ST_FETCH;
        end
      end

      ST_FILL: begin
        state_d   = ST_IDLE;
        busy_d    = 1'b0;
        mem_req_d = 1'b0;
      end

      default: begin
        state_d   = ST_IDLE;
        idx_d     = {IDX_W{1'b0}};
        busy_d    = 1'b0;
        mem_req_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset discards any partial line
  always_ff @(posedge inp_clk or negedge inp_rst_n) begin
    if (!inp_rst_n) begin
      state_q      <= ST_IDLE;
      idx_q        <= {IDX_W{1'b0}};
      base_q       <= {ADDR_W{1'b0}};
      busy_q       <= 1'b0;
      mem_req_q    <= 1'b0;
      mem_addr_q   <= {ADDR_W{1'b0}};
      line_data_q  <= {LINE_WL{1'b0}};
      line_addr_q  <= {ADDR_W{1'b0}};
      line_valid_q <= 1'b0;
      for (int k = 0; k < LINE_WORDS; k++) begin
        wbuf_q[k] <= {WORD_W{1'b0}};
      end
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      base_q       <= base_d;
      busy_q       <= busy_d;
      mem_req_q    <= mem_req_d;
      mem_addr_q   <= mem_addr_d;
      line_data_q  <= line_data_d;
      line_addr_q  <= line_addr_d;
      line_valid_q <= line_valid_d;
      wbuf_q       <= wbuf_d;
    end
  end

  assign bus.out_busy       = busy_q;
  assign bus.out_mem_req    = mem_req_q;
  assign bus.out_mem_addr   = mem_addr_q;
  assign bus.out_lineData   = line_data_q;
  assign bus.out_line_addr  = line_addr_q;
  assign bus.out_line_valid = line_valid_q;

endmodule

// File: tb/tb_cache_refill.sv
// Scoreboard bench for cache_refill: a memory responder and a line monitor
// check the DUT against expectations pushed by the stimulus process.
module tb_cache_refill;

  typedef struct packed {
    logic [63:0] data;
    logic [15:0] addr;
  } line_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  cache_refill_if #(.ADDR_W(16), .WORD_W(16), .LINE_WORDS(4)) bus ();

  cache_refill #(.ADDR_W(16), .WORD_W(16), .LINE_WORDS(4)) dut (
    .inp_clk   (clk),
    .inp_rst_n (rst_n),
    .bus       (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference memory contents and expectation queues
  logic [15:0] mem [logic [15:0]];
  logic [15:0] addr_q [$];
  line_t       line_q [$];

  int          wait_mode = 0;
  bit          spur = 1'b0;
  int          acks = 0;
  int          fills = 0;
  int          last_valid_cyc = 0;

  // responder-private state
  int          wl = 0;
  bit          need_new = 1'b1;
  logic [15:0] exp_a;
  // monitor-private state
  bit          prev_v = 1'b0;
  logic [63:0] last_line = 64'h0;
  logic [15:0] last_addr = 16'h0;
  line_t       got_e;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Memory model: optional wait states, returns stored data on ack
  initial begin : responder
    bus.inp_mem_ack  = 1'b0;
    bus.inp_mem_data = 16'h0;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_mem_req) begin
        if (need_new) begin
          wl = (wait_mode < 0) ? int'($urandom_range(0, 3)) : wait_mode;
          need_new = 1'b0;
        end
        if (addr_q.size() == 0) begin
          check("mem_req_unexpected", 64'd1, 64'd0);
          bus.inp_mem_ack = 1'b0;
        end else if (wl > 0) begin
          check("mem_addr_wait", {48'h0, bus.out_mem_addr}, {48'h0, addr_q[0]});
          bus.inp_mem_ack  = 1'b0;
          bus.inp_mem_data = 16'($urandom);
          wl--;
        end else begin
          exp_a = addr_q.pop_front();
          check("mem_addr", {48'h0, bus.out_mem_addr}, {48'h0, exp_a});
          bus.inp_mem_ack  = 1'b1;
          bus.inp_mem_data = mem.exists(exp_a) ? mem[exp_a] : 16'h0;
          need_new = 1'b1;
          acks++;
        end
      end else begin
        bus.inp_mem_ack  = spur;
        bus.inp_mem_data = spur ? 16'h5555 : 16'h0000;
        need_new = 1'b1;
      end
    end
  end

  // Line monitor: compares each fill pulse, checks hold between fills
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        last_line = 64'h0;
        last_addr = 16'h0;
        check("rst_line_data", bus.out_lineData, 64'h0);
        check("rst_valid", {63'h0, bus.out_line_valid}, 64'h0);
      end else if (bus.out_line_valid) begin
        check("valid_one_cycle", {63'h0, prev_v}, 64'h0);
        if (line_q.size() == 0) begin
          check("fill_unexpected", 64'd1, 64'd0);
        end else begin
          got_e = line_q.pop_front();
          check("line_data", bus.out_lineData, got_e.data);
          check("line_addr", {48'h0, bus.out_line_addr}, {48'h0, got_e.addr});
          last_line = got_e.data;
          last_addr = got_e.addr;
        end
        fills++;
        last_valid_cyc = cyc;
      end else begin
        check("line_hold", bus.out_lineData, last_line);
        check("addr_hold", {48'h0, bus.out_line_addr}, {48'h0, last_addr});
      end
      prev_v = bus.out_line_valid;
    end
  end

  // Queue expectations for one line at base b
  task automatic expect_line(input logic [15:0] b, input bit rnd);
    line_t e;
    for (int k = 0; k < 4; k++) begin
      if (rnd) mem[b + 16'(2 * k)] = 16'($urandom);
      addr_q.push_back(b + 16'(2 * k));
    end
    e.data = {mem[b + 16'd6], mem[b + 16'd4], mem[b + 16'd2], mem[b]};
    e.addr = b;
    line_q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 one edge after the fill pulse
  task automatic do_refill(input logic [15:0] a, input int waits, input bit spam, input bit rnd);
    int f0;
    int e0;
    int t;
    expect_line({a[15:3], 3'b000}, rnd);
    wait_mode = waits;
    f0 = fills;
    bus.inp_miss    = 1'b1;
    bus.inp_address = a;
    @(posedge clk); #1;
    e0 = cyc;
    if (spam) bus.inp_address = 16'h4000;
    else      bus.inp_miss    = 1'b0;
    t = 0;
    while (fills == f0 && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    bus.inp_miss = 1'b0;
    if (fills == f0) check("fill_timeout", 64'(fills), 64'(f0 + 1));
    else if (waits >= 0) check("fill_latency", 64'(last_valid_cyc - e0), 64'(4 + 4 * waits));
  endtask

  initial begin : stim
    int a0;
    int f0;
    int t;
    int w;
    bus.inp_miss    = 1'b0;
    bus.inp_address = 16'h0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {63'h0, bus.out_busy}, 64'h0);
    check("reset_req", {63'h0, bus.out_mem_req}, 64'h0);
    check("reset_mem_addr", {48'h0, bus.out_mem_addr}, 64'h0);
    check("reset_line_addr", {48'h0, bus.out_line_addr}, 64'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // directed line at 0x1234, no waits then 2 waits per word
    mem[16'h1230] = 16'hAAAA;
    mem[16'h1232] = 16'hBBBB;
    mem[16'h1234] = 16'hCCCC;
    mem[16'h1236] = 16'hDDDD;
    do_refill(16'h1234, 0, 1'b0, 1'b0);
    check("t1_line", bus.out_lineData, 64'hDDDD_CCCC_BBBB_AAAA);
    do_refill(16'h1234, 2, 1'b0, 1'b0);

    // second miss held during refill is ignored
    do_refill(16'h1234, 0, 1'b1, 1'b0);
    f0 = fills;
    repeat (4) @(posedge clk);
    #1;
    check("spam_idle_busy", {63'h0, bus.out_busy}, 64'h0);
    check("spam_one_fill", 64'(fills), 64'(f0));
    do_refill(16'h4000, 0, 1'b0, 1'b1);

    // top of address space
    do_refill(16'hFFFE, 1, 1'b0, 1'b1);
    check("top_line_addr", {48'h0, bus.out_line_addr}, 64'hFFF8);

    // reset after two of four words
    expect_line(16'h2468, 1'b1);
    wait_mode = 0;
    a0 = acks;
    f0 = fills;
    bus.inp_miss    = 1'b1;
    bus.inp_address = 16'h246A;
    @(posedge clk); #1;
    bus.inp_miss = 1'b0;
    t = 0;
    while (acks < a0 + 2 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    check("mid_acks", 64'(acks), 64'(a0 + 2));
    rst_n = 1'b0;
    addr_q.delete();
    line_q.delete();
    #1;
    check("mid_rst_busy", {63'h0, bus.out_busy}, 64'h0);
    check("mid_rst_req", {63'h0, bus.out_mem_req}, 64'h0);
    check("mid_rst_addr", {48'h0, bus.out_mem_addr}, 64'h0);
    check("mid_rst_line", bus.out_lineData, 64'h0);
    check("mid_rst_laddr", {48'h0, bus.out_line_addr}, 64'h0);
    check("mid_rst_valid", {63'h0, bus.out_line_valid}, 64'h0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    check("mid_no_fill", 64'(fills), 64'(f0));
    do_refill(16'h2468, 0, 1'b0, 1'b1);

    // spurious ack while idle
    f0 = fills;
    spur = 1'b1;
    repeat (3) @(posedge clk);
    #1 spur = 1'b0;
    @(posedge clk); #1;
    check("spur_busy", {63'h0, bus.out_busy}, 64'h0);
    check("spur_no_fill", 64'(fills), 64'(f0));

    // random refills
    for (int i = 0; i < 24; i++) begin
      w = ($urandom_range(0, 1) == 0) ? -1 : int'($urandom_range(0, 2));
      do_refill(16'($urandom), w, 1'($urandom_range(0, 1)), 1'b1);
    end

    repeat (4) @(posedge clk);
    #1;
    check("addr_q_drained", 64'(addr_q.size()), 64'd0);
    check("line_q_drained", 64'(line_q.size()), 64'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
